// File: rtl/ctr_pkg.sv
// Shared definitions for the CTR stream sequencer: sizes, FSM encodings, job payload and counter helpers.
// ctr_tail_mask is only referenced when CTR_SEQ_PARTIAL_EN is defined.
package ctr_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned KEY_W   = 256;
    localparam int unsigned ST_W    = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_FETCH = 3'd1;
    localparam logic [ST_W-1:0] ST_START = 3'd2;
    localparam logic [ST_W-1:0] ST_BUSY  = 3'd3;
    localparam logic [ST_W-1:0] ST_EMIT  = 3'd4;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd5;

    typedef struct packed {
        logic [BLOCK_W-1:0] counter;
        logic [KEY_W-1:0]   key;
        logic               keylen;
    } ctr_job_t;

    // Increment the low inc_w bits modulo 2^inc_w, leaving the upper bits untouched.
    function automatic logic [BLOCK_W-1:0] ctr_inc(input logic [BLOCK_W-1:0] ctr,
                                                   input int unsigned inc_w);
        logic [BLOCK_W-1:0] low_mask;
        if (inc_w >= BLOCK_W) begin
            low_mask = '1;
        end else begin
            low_mask = (BLOCK_W'(1) << inc_w) - BLOCK_W'(1);
        end
        return (ctr & ~low_mask) | ((ctr + BLOCK_W'(1)) & low_mask);
    endfunction

    // Keep the leading 'bytes' bytes (byte 0 = bits [127:120]); 0 keeps all 16.
    function automatic logic [BLOCK_W-1:0] ctr_tail_mask(input logic [3:0] bytes);
        logic [BLOCK_W-1:0] ones;
        int unsigned        n;
        ones = '1;
        n    = (bytes == 4'd0) ? 16 : int'(bytes);
        return ~(ones >> (8 * n));
    endfunction

endpackage

// File: rtl/ctr_stream_sequencer.sv
// Drives ctr_core across a multi-block CTR job: one descriptor, then fetch/start/collect/emit per block.
// Optional CTR_SEQ_PARTIAL_EN adds cfg_last_bytes and zeroes the unused tail bytes of the final block.
module ctr_stream_sequencer
    import ctr_pkg::*;
#(
    parameter int unsigned NB_W  = 16,
    parameter int unsigned INC_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [BLOCK_W-1:0] cfg_counter,
    input  logic [KEY_W-1:0]   cfg_key,
    input  logic               cfg_keylen,
    input  logic [NB_W-1:0]    cfg_nblocks,
`ifdef CTR_SEQ_PARTIAL_EN
    input  logic [3:0]         cfg_last_bytes,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_last,
    output logic               done,
    output logic               busy,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_counter,
    output logic [KEY_W-1:0]   core_key,
    output logic               core_keylen,
    output logic [BLOCK_W-1:0] core_block_i,
    input  logic [BLOCK_W-1:0] core_block_o,
    input  logic               core_ready
);

    logic [ST_W-1:0]    state, state_nxt;
    ctr_job_t           job_q, job_nxt;
    logic [NB_W-1:0]    remaining_q, remaining_nxt;
    logic [BLOCK_W-1:0] block_nxt, data_nxt;
    logic               last_nxt;
    logic               guard_q;
    logic               is_last;
`ifdef CTR_SEQ_PARTIAL_EN
    logic [3:0]         last_bytes_q, last_bytes_nxt;
`endif

    assign core_counter = job_q.counter;
    assign core_key     = job_q.key;
    assign core_keylen  = job_q.keylen;
    assign is_last      = (remaining_q == NB_W'(1));

    // Next-state and datapath update
    always_comb begin
        state_nxt     = state;
        job_nxt       = job_q;
        remaining_nxt = remaining_q;
        block_nxt     = core_block_i;
        data_nxt      = out_data;
        last_nxt      = out_last;
`ifdef CTR_SEQ_PARTIAL_EN
        last_bytes_nxt = last_bytes_q;
`endif
        case (state)
            ST_IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    job_nxt       = '{counter: cfg_counter, key: cfg_key, keylen: cfg_keylen};
                    remaining_nxt = cfg_nblocks;
`ifdef CTR_SEQ_PARTIAL_EN
                    last_bytes_nxt = cfg_last_bytes;
`endif
                    state_nxt     = (cfg_nblocks == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (in_valid && in_ready) begin
                    block_nxt = in_data;
                    state_nxt = ST_START;
                end
            end
            ST_START: state_nxt = ST_BUSY;
            ST_BUSY: begin
                // guard_q masks a core_ready that has not yet dropped after core_start
                if (!guard_q && core_ready) begin
`ifdef CTR_SEQ_PARTIAL_EN
                    data_nxt = is_last ? (core_block_o & ctr_tail_mask(last_bytes_q)) : core_block_o;
`else
                    data_nxt = core_block_o;
`endif
                    last_nxt  = is_last;
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_valid && out_ready) begin
                    remaining_nxt   = remaining_q - NB_W'(1);
                    job_nxt.counter = ctr_inc(job_q.counter, INC_W);
                    state_nxt       = is_last ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs derived from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            job_q        <= '0;
            remaining_q  <= '0;
            core_block_i <= '0;
            out_data     <= '0;
            out_last     <= 1'b0;
            guard_q      <= 1'b0;
            cfg_ready    <= 1'b0;
            in_ready     <= 1'b0;
            core_start   <= 1'b0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
`ifdef CTR_SEQ_PARTIAL_EN
            last_bytes_q <= '0;
`endif
        end else begin
            state        <= state_nxt;
            job_q        <= job_nxt;
            remaining_q  <= remaining_nxt;
            core_block_i <= block_nxt;
            out_data     <= data_nxt;
            out_last     <= last_nxt;
            guard_q      <= (state_nxt == ST_BUSY) && (state != ST_BUSY);
            cfg_ready    <= (state_nxt == ST_IDLE);
            in_ready     <= (state_nxt == ST_FETCH);
            core_start   <= (state_nxt == ST_START);
            out_valid    <= (state_nxt == ST_EMIT);
            done         <= (state_nxt == ST_DONE);
            busy         <= (state_nxt != ST_IDLE);
`ifdef CTR_SEQ_PARTIAL_EN
            last_bytes_q <= last_bytes_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ctr_stream_sequencer.sv
// Bench for ctr_stream_sequencer: behavioural core model, job-level reference, directed plus random jobs.
// Honours CTR_SEQ_PARTIAL_EN to exercise the partial final block.
module tb_ctr_stream_sequencer;

    logic         clk = 1'b0;
    logic         resetn;
    logic         cfg_valid, cfg_ready;
    logic [127:0] cfg_counter;
    logic [255:0] cfg_key;
    logic         cfg_keylen;
    logic [15:0]  cfg_nblocks;
`ifdef CTR_SEQ_PARTIAL_EN
    logic [3:0]   cfg_last_bytes;
`endif
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic         out_valid, out_ready, out_last;
    logic [127:0] out_data;
    logic         done, busy, core_start, core_keylen, core_ready;
    logic [127:0] core_counter, core_block_i, core_block_o;
    logic [255:0] core_key;

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_start = 0, n_inrdy = 0, n_outv = 0;

    always #5 clk = ~clk;

    ctr_stream_sequencer dut (
        .clk(clk), .resetn(resetn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_counter(cfg_counter),
        .cfg_key(cfg_key), .cfg_keylen(cfg_keylen), .cfg_nblocks(cfg_nblocks),
`ifdef CTR_SEQ_PARTIAL_EN
        .cfg_last_bytes(cfg_last_bytes),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .busy(busy), .core_start(core_start), .core_counter(core_counter),
        .core_key(core_key), .core_keylen(core_keylen), .core_block_i(core_block_i),
        .core_block_o(core_block_o), .core_ready(core_ready)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Stand-in for ctr_core: an invertible keyed mix of counter and plaintext.
    function automatic logic [127:0] core_fn(input logic [127:0] c, input logic [255:0] k,
                                             input logic kl, input logic [127:0] b);
        return b ^ c ^ {c[95:0], c[127:96]} ^ k[127:0] ^ (kl ? k[255:128] : 128'h0);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core model with random latency; result becomes valid when core_ready rises again.
    int           lat_cnt;
    logic [127:0] pending;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            core_ready   <= 1'b1;
            core_block_o <= '0;
            lat_cnt      <= 0;
            pending      <= '0;
        end else if (core_start) begin
            core_ready <= 1'b0;
            lat_cnt    <= int'($urandom_range(1, 6));
            pending    <= core_fn(core_counter, core_key, core_keylen, core_block_i);
        end else if (!core_ready) begin
            if (lat_cnt == 0) begin
                core_ready   <= 1'b1;
                core_block_o <= pending;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        if (done)       n_done  <= n_done + 1;
        if (core_start) n_start <= n_start + 1;
        if (in_ready)   n_inrdy <= n_inrdy + 1;
        if (out_valid)  n_outv  <= n_outv + 1;
    end

    task automatic run_job(input logic [127:0] ctr, input logic [255:0] key, input logic kl,
                           input int n, input logic [3:0] lb, input int hold, input int abort_blk);
        int           t, d0, s0, r0, o0, nb;
        logic [127:0] pt, exp, ectr, hd;
        logic         hl, stable;
        d0 = n_done;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_counter = ctr; cfg_key = key; cfg_keylen = kl; cfg_nblocks = 16'(n);
`ifdef CTR_SEQ_PARTIAL_EN
        cfg_last_bytes = lb;
`endif
        t = 0;
        while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
        chk("cfg_accept", 256'(cfg_ready), 256'(1));
        @(negedge clk);
        cfg_valid = 1'b0;
        if (n == 0) begin
            s0 = n_start; o0 = n_outv;
            chk("zero_done_pulse", 256'(done), 256'(1));
            @(negedge clk);
            chk("zero_done_low", 256'(done), 256'(0));
            repeat (3) @(negedge clk);
            chk("zero_no_start", 256'(n_start - s0), 256'(0));
            chk("zero_no_out", 256'(n_outv - o0), 256'(0));
            chk("zero_done_once", 256'(n_done - d0), 256'(1));
            return;
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pt = rnd128();
            in_valid = 1'b1; in_data = pt;
            t = 0;
            while (!in_ready && t < 50) begin @(negedge clk); t++; end
            chk("in_accept", 256'(in_ready), 256'(1));
            @(negedge clk);
            in_valid = 1'b0;
            ectr = {ctr[127:32], ctr[31:0] + 32'(i)};
            chk("core_start", 256'(core_start), 256'(1));
            chk("core_counter", 256'(core_counter), 256'(ectr));
            chk("core_key", core_key, key);
            chk("core_block_i", 256'(core_block_i), 256'(pt));
            chk("busy", 256'(busy), 256'(1));
            if (i == abort_blk) begin
                @(negedge clk);
                resetn = 1'b0;
                #1;
                chk("abort_outs", 256'({cfg_ready, in_ready, out_valid, out_last, done, busy, core_start, core_keylen}), 256'(0));
                chk("abort_regs", 256'(core_counter | core_block_i | out_data), 256'(0));
                @(negedge clk);
                resetn = 1'b1;
                @(negedge clk);
                chk("abort_cfg_ready", 256'(cfg_ready), 256'(1));
                chk("abort_idle_busy", 256'(busy), 256'(0));
                chk("abort_no_done", 256'(n_done - d0), 256'(0));
                return;
            end
            t = 0;
            while (!out_valid && t < 100) begin @(negedge clk); t++; end
            chk("out_valid", 256'(out_valid), 256'(1));
            exp = core_fn(ectr, key, kl, pt);
`ifdef CTR_SEQ_PARTIAL_EN
            nb = (lb == 4'd0) ? 16 : int'(lb);
            if (i == n - 1)
                for (int b = nb; b < 16; b++) exp[127 - 8*b -: 8] = 8'h00;
`else
            nb = 16;
`endif
            chk("out_data", 256'(out_data), 256'(exp));
            chk("out_last", 256'(out_last), 256'(i == n - 1));
            hd = out_data; hl = out_last; s0 = n_start; r0 = n_inrdy; stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!(out_valid && out_data == hd && out_last == hl)) stable = 1'b0;
            end
            if (hold > 0) begin
                chk("hold_stable", 256'(stable), 256'(1));
                chk("hold_no_start", 256'(n_start - s0), 256'(0));
                chk("hold_no_in_ready", 256'(n_inrdy - r0), 256'(0));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("out_valid_drop", 256'(out_valid), 256'(0));
        end
        chk("done_pulse", 256'(done), 256'(1));
        @(negedge clk);
        chk("done_low", 256'(done), 256'(0));
        chk("done_once", 256'(n_done - d0), 256'(1));
    endtask

    initial begin
        resetn = 1'b0; cfg_valid = 1'b0; cfg_counter = '0; cfg_key = '0; cfg_keylen = 1'b0;
        cfg_nblocks = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef CTR_SEQ_PARTIAL_EN
        cfg_last_bytes = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_outs", 256'({cfg_ready, in_ready, out_valid, out_last, done, busy, core_start, core_keylen}), 256'(0));
        chk("rst_data", 256'(out_data | core_counter | core_block_i), 256'(0));
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_cfg_ready", 256'(cfg_ready), 256'(1));
        chk("post_rst_busy", 256'(busy), 256'(0));

        // AES-256 style 4-block job, no backpressure
        run_job(128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff,
                256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                1'b1, 4, 4'd0, 0, -1);
        // Counter low-word wrap
        run_job({96'h0123456789abcdef01234567, 32'hFFFF_FFFF}, {8{$urandom}}, 1'b0, 2, 4'd0, 0, -1);
        // Empty job
        run_job(rnd128(), {8{$urandom}}, 1'b1, 0, 4'd0, 0, -1);
        // Long output backpressure
        run_job(rnd128(), {8{$urandom}}, 1'b0, 1, 4'd0, 20, -1);
        // Reset during BUSY of block 2 of 3
        run_job(rnd128(), {8{$urandom}}, 1'b1, 3, 4'd0, 0, 1);
`ifdef CTR_SEQ_PARTIAL_EN
        run_job(rnd128(), {8{$urandom}}, 1'b1, 1, 4'd5, 0, -1);
`endif
        for (int j = 0; j < 12; j++) begin
            run_job({rnd128()}, {rnd128(), rnd128()}, 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 5)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 4)), -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
